// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, FSM state types and byte-strobe merge
package axi4_lite_pkg;

  localparam logic [1:0] AXI4_LITE_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_LITE_SLVERR = 2'b10;

  // Widest data bus the strobe merge helper can serve, in bytes.
  localparam int AXI4_LITE_MAX_BYTES = 64;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_RESP    = 2'd1,
    W_COLLECT = 2'd2
  } axi4_lite_wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } axi4_lite_rd_state_t;

  function automatic logic [8*AXI4_LITE_MAX_BYTES-1:0] axi4_lite_strb_merge(
    input logic [8*AXI4_LITE_MAX_BYTES-1:0] old_v,
    input logic [8*AXI4_LITE_MAX_BYTES-1:0] wdata_v,
    input logic [AXI4_LITE_MAX_BYTES-1:0]   wstrb_v
  );
    logic [8*AXI4_LITE_MAX_BYTES-1:0] res;
    for (int k = 0; k < AXI4_LITE_MAX_BYTES; k++) begin
      res[8*k +: 8] = wstrb_v[k] ? wdata_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_decode.sv
// rtl/axi4_lite_reg_decode.sv - byte address to register index decoder with range hit
module axi4_lite_reg_decode #(
  parameter int A    = 8,
  parameter int N    = 4,
  parameter int REGS = 8,
  parameter int IW   = 3
) (
  input  logic [A-1:0]  addr,
  output logic [IW-1:0] index,
  output logic          hit
);
  import axi4_lite_pkg::*;

  localparam int LB = $clog2(N);
  localparam int FW = A - LB;

  logic [FW-1:0] field;

  assign field = addr[A-1:LB];
  assign hit   = 32'(field) < 32'(REGS);
  assign index = field[IW-1:0];

  // Sub-word address bits carry no meaning for word-wide registers.
  if (LB > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^addr[LB-1:0];
  end

endmodule

// File: rtl/axi4_lite_register_file.sv
// rtl/axi4_lite_register_file.sv - AXI4-Lite slave register bank; AXI4_LITE_REG_FILE_STRB_EN enables byte strobes
module axi4_lite_register_file
  import axi4_lite_pkg::*;
#(
  parameter int A    = 8,
  parameter int N    = 4,
  parameter int REGS = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [A-1:0]          awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [8*N-1:0]        wdata,
  input  logic [N-1:0]          wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [A-1:0]          araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [8*N-1:0]        rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [REGS*8*N-1:0]   reg_q,
  output logic [REGS-1:0]       reg_wr
);

  localparam int DW = 8 * N;
  localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;

  axi4_lite_wr_state_t w_state_q, w_state_d;
  axi4_lite_rd_state_t r_state_q, r_state_d;

  logic            ready_en_q;
  logic            have_aw_q;
  logic [IW-1:0]   aw_idx_q;
  logic            aw_hit_q;
  logic [DW-1:0]   w_data_q;
  logic [DW-1:0]   regs_q [REGS];
  logic [REGS-1:0] reg_wr_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;

  logic [IW-1:0]   aw_idx, ar_idx, c_idx;
  logic            aw_hit, ar_hit, c_hit;
  logic            aw_hs, w_hs, ar_hs, commit;
  logic [DW-1:0]   c_data, wr_val;

  axi4_lite_reg_decode #(.A(A), .N(N), .REGS(REGS), .IW(IW)) u_aw_dec (
    .addr(awaddr), .index(aw_idx), .hit(aw_hit)
  );

  axi4_lite_reg_decode #(.A(A), .N(N), .REGS(REGS), .IW(IW)) u_ar_dec (
    .addr(araddr), .index(ar_idx), .hit(ar_hit)
  );

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  // In W_COLLECT only the missing channel is ready, so any handshake completes the pair.
  assign commit = ((w_state_q == W_IDLE) && aw_hs && w_hs) ||
                  ((w_state_q == W_COLLECT) && (aw_hs || w_hs));
  assign c_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign c_hit  = aw_hs ? aw_hit : aw_hit_q;
  assign c_data = w_hs ? wdata : w_data_q;

`ifdef AXI4_LITE_REG_FILE_STRB_EN
  logic [N-1:0]                     w_strb_q;
  logic [N-1:0]                     c_strb;
  logic [8*AXI4_LITE_MAX_BYTES-1:0] old_w, new_w, mrg_w;
  logic [AXI4_LITE_MAX_BYTES-1:0]   strb_w;

  always_ff @(posedge aclk) begin
    if (areset)                          w_strb_q <= '0;
    else if (w_state_q == W_IDLE && w_hs) w_strb_q <= wstrb;
  end

  assign c_strb = w_hs ? wstrb : w_strb_q;

  always_comb begin
    old_w = '0;
    new_w = '0;
    strb_w = '0;
    old_w[DW-1:0] = regs_q[c_idx];
    new_w[DW-1:0] = c_data;
    strb_w[N-1:0] = c_strb;
    mrg_w  = axi4_lite_strb_merge(old_w, new_w, strb_w);
    wr_val = mrg_w[DW-1:0];
  end
`else
  logic unused_strb;
  assign unused_strb = ^wstrb;
  assign wr_val      = c_data;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:    if (aw_hs && w_hs) w_state_d = W_RESP;
                 else if (aw_hs || w_hs) w_state_d = W_COLLECT;
      W_COLLECT: if (aw_hs || w_hs) w_state_d = W_RESP;
      W_RESP:    if (bready) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE:    begin awready = ready_en_q; wready = ready_en_q; end
      W_COLLECT: begin awready = !have_aw_q; wready = have_aw_q; end
      W_RESP:    bvalid = 1'b1;
      default:   ;
    endcase
    arready = ready_en_q && (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      have_aw_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_hit_q  <= 1'b0;
      w_data_q  <= '0;
    end else if (w_state_q == W_IDLE) begin
      have_aw_q <= aw_hs;
      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_hit_q <= aw_hit;
      end
      if (w_hs) w_data_q <= wdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
      reg_wr_q <= '0;
      bresp_q  <= AXI4_LITE_OKAY;
    end else begin
      reg_wr_q <= '0;
      if (commit) begin
        bresp_q <= c_hit ? AXI4_LITE_OKAY : AXI4_LITE_SLVERR;
        if (c_hit) begin
          regs_q[c_idx]   <= wr_val;
          reg_wr_q[c_idx] <= 1'b1;
        end
      end
    end
  end

  // Reads sample regs_q before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= AXI4_LITE_OKAY;
    end else if (ar_hs) begin
      rdata_q <= ar_hit ? regs_q[ar_idx] : '0;
      rresp_q <= ar_hit ? AXI4_LITE_OKAY : AXI4_LITE_SLVERR;
    end
  end

  for (genvar i = 0; i < REGS; i++) begin : g_flat
    assign reg_q[i*DW +: DW] = regs_q[i];
  end

  assign reg_wr = reg_wr_q;
  assign bresp  = bresp_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_register_file.sv
// tb/tb_axi4_lite_register_file.sv - directed self-checking bench for axi4_lite_register_file
module tb_axi4_lite_register_file;

  localparam int A = 8;
  localparam int N = 4;
  localparam int REGS = 8;

  logic                aclk, areset;
  logic [A-1:0]        awaddr, araddr;
  logic                awvalid, awready, wvalid, wready, bvalid, bready;
  logic                arvalid, arready, rvalid, rready;
  logic [31:0]         wdata, rdata;
  logic [3:0]          wstrb;
  logic [1:0]          bresp, rresp;
  logic [REGS*32-1:0]  reg_q;
  logic [REGS-1:0]     reg_wr;

  logic [REGS*32-1:0]  exp_regs;
  logic [31:0]         exp_strb;
  int n_assert = 0;
  int n_fail = 0;

  axi4_lite_register_file #(.A(A), .N(N), .REGS(REGS)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge aclk); #1;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr);
    @(posedge aclk); #1;
    araddr = addr; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic take_b;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic take_r;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    exp_regs = '0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_reg_q", reg_q, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", {bresp, rresp}, 0);

    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("idle_readies", {awready, wready, arready}, 3'b111);

    // AW and W together to register 1
    do_write(8'h04, 32'hDEADBEEF, 4'hF);
    @(negedge aclk);
    exp_regs[32*1 +: 32] = 32'hDEADBEEF;
    check("w1_bvalid", bvalid, 1);
    check("w1_bresp", bresp, 2'b00);
    check("w1_reg_wr", reg_wr, 8'b0000_0010);
    check("w1_reg_q", reg_q, exp_regs);
    check("w1_readies_low", {awready, wready}, 2'b00);
    take_b();
    @(negedge aclk);
    check("w1_bvalid_clr", bvalid, 0);
    check("w1_reg_wr_clr", reg_wr, 0);

    do_read(8'h04);
    @(negedge aclk);
    check("r1_rvalid", rvalid, 1);
    check("r1_rdata", rdata, 32'hDEADBEEF);
    check("r1_rresp", rresp, 2'b00);
    check("r1_arready_low", arready, 0);
    take_r();
    @(negedge aclk);
    check("r1_rvalid_clr", rvalid, 0);

    // W leads AW by three cycles, register 2
    @(posedge aclk); #1;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    @(negedge aclk);
    check("w2_wready_drop", {wready, awready}, 2'b01);
    check("w2_no_bvalid", bvalid, 0);
    @(posedge aclk);
    @(posedge aclk); #1;
    awaddr = 8'h08; awvalid = 1'b1;
    @(negedge aclk);
    check("w2_not_committed", reg_q, exp_regs);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    exp_regs[32*2 +: 32] = 32'h12345678;
    check("w2_bvalid", bvalid, 1);
    check("w2_reg_q", reg_q, exp_regs);
    check("w2_reg_wr", reg_wr, 8'b0000_0100);
    take_b();

    // AW leads W by one cycle, register 5
    @(posedge aclk); #1;
    awaddr = 8'h14; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("w5_collect_readies", {awready, wready}, 2'b01);
    @(posedge aclk); #1;
    wdata = 32'h55AA55AA; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    @(negedge aclk);
    exp_regs[32*5 +: 32] = 32'h55AA55AA;
    check("w5_bvalid", bvalid, 1);
    check("w5_reg_q", reg_q, exp_regs);
    check("w5_reg_wr", reg_wr, 8'b0010_0000);
    take_b();

    // Out-of-range address 0x40
    do_read(8'h40);
    @(negedge aclk);
    check("rerr_rresp", rresp, 2'b10);
    check("rerr_rdata", rdata, 0);
    take_r();
    do_write(8'h40, 32'hA5A5A5A5, 4'hF);
    @(negedge aclk);
    check("werr_bresp", bresp, 2'b10);
    check("werr_reg_wr", reg_wr, 0);
    check("werr_reg_q", reg_q, exp_regs);
    take_b();

    // Backpressure: write reg 3 and read reg 2 concurrently, responses held 5 cycles
    @(posedge aclk); #1;
    awaddr = 8'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h08; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_regs[32*3 +: 32] = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bp_valids", {bvalid, rvalid}, 2'b11);
      check("bp_readies", {awready, wready, arready}, 3'b000);
      check("bp_rdata", rdata, 32'h12345678);
      check("bp_bresp", {bresp, rresp}, 4'b0000);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    @(negedge aclk);
    check("bp_release", {bvalid, rvalid}, 2'b00);
    check("bp_reg_q", reg_q, exp_regs);

    // Read and write to register 3 on the same edge: read returns the old value
    @(posedge aclk); #1;
    awaddr = 8'h0C; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h0C; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    exp_regs[32*3 +: 32] = 32'h11112222;
    check("coll_rdata", rdata, 32'hCAFEF00D);
    check("coll_reg_q", reg_q, exp_regs);
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;

    // Strobe handling on register 0
    do_write(8'h00, 32'hFFFFFFFF, 4'hF);
    take_b();
    do_write(8'h00, 32'h00000000, 4'b0101);
    @(negedge aclk);
`ifdef AXI4_LITE_REG_FILE_STRB_EN
    exp_strb = 32'hFF00FF00;
`else
    exp_strb = 32'h00000000;
`endif
    exp_regs[32*0 +: 32] = exp_strb;
    check("strb_reg_q", reg_q, exp_regs);
    check("strb_reg_wr", reg_wr, 8'b0000_0001);
    check("strb_bresp", bresp, 2'b00);
    take_b();

    // Reset with a response pending on both channels
    do_write(8'h18, 32'h0BADF00D, 4'hF);
    do_read(8'h04);
    @(negedge aclk);
    check("pre_rst_valids", {bvalid, rvalid}, 2'b11);
    areset = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    check("mid_rst_reg_q", reg_q, 0);
    check("mid_rst_readies", {awready, wready, arready}, 3'b000);
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
